// File: rtl/mux_scan_sel_if.sv
// Bus bundle for mux_scan_sel.
//   master : drives channel data and controls, observes the selected output.
//   slave  : the multiplexer itself.
// Signals:
//   din       channel data, channel k at din[k*WIDTH +: WIDTH]
//   mode      0 = manual select, 1 = round-robin scan
//   sel_in    channel index loaded by sel_load (manual mode)
//   sel_load  single-cycle load strobe for sel_in
//   chan_en   scan-mode channel enable mask
//   hold      freezes all selector state and the output
//   out       registered selected data
//   out_valid out carries data from a legal, enabled channel
//   cur_sel   channel currently selected
//   sel_err   one-cycle pulse on a load of an out-of-range index
//   scan_wrap one-cycle pulse when a scan advance wraps to a lower index
interface mux_scan_sel_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = 2
);
  logic [NCH*WIDTH-1:0] din;
  logic                 mode;
  logic [SELW-1:0]      sel_in;
  logic                 sel_load;
  logic [NCH-1:0]       chan_en;
  logic                 hold;
  logic [WIDTH-1:0]     out;
  logic                 out_valid;
  logic [SELW-1:0]      cur_sel;
  logic                 sel_err;
  logic                 scan_wrap;

  modport master (
    output din, mode, sel_in, sel_load, chan_en, hold,
    input  out, out_valid, cur_sel, sel_err, scan_wrap
  );

  modport slave (
    input  din, mode, sel_in, sel_load, chan_en, hold,
    output out, out_valid, cur_sel, sel_err, scan_wrap
  );
endinterface

// File: rtl/mux_scan_sel.sv
// Registered NCH-channel, WIDTH-bit multiplexer with manual and scan selection.
// Manual mode loads the select through a strobe; scan mode steps round-robin
// through the enabled channels, dwelling DWELL cycles on each.
// Ports:
//   clk  single clock, rising edge
//   rst  synchronous active-high reset, highest priority
//   bus  mux_scan_sel_if.slave (data, controls, registered outputs)
// All outputs come straight from flops.
module mux_scan_sel #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = 2,
  parameter int DWELL = 4
) (
  input logic           clk,
  input logic           rst,
  mux_scan_sel_if.slave bus
);

  localparam int              CNTW      = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int              NSEL      = 1 << SELW;
  localparam logic [CNTW-1:0] DwellLast = CNTW'(DWELL - 1);

  typedef enum logic [1:0] {StIdle, StMan, StScan} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  cur_sel_q, cur_sel_d;
  logic [CNTW-1:0]  dwell_q, dwell_d;
  logic             sel_err_q, sel_err_d;
  logic             scan_wrap_q, scan_wrap_d;

  logic [WIDTH-1:0] ch_data [NCH];
  logic [NSEL-1:0]  sel_legal;
  logic [SELW-1:0]  nxt_sel;
  logic [SELW-1:0]  probe_idx;
  logic             nxt_found;
  logic             cur_en;

  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      ch_data[k] = bus.din[k*WIDTH +: WIDTH];
    end
  end

  // Select codes at or above NCH are unreachable channels.
  always_comb begin
    for (int i = 0; i < NSEL; i++) begin
      sel_legal[i] = (i < NCH);
    end
  end

  assign cur_en = bus.chan_en[cur_sel_q];

  // First enabled channel strictly after cur_sel, modulo NCH. The last probe
  // lands on cur_sel itself, so a lone enabled channel selects itself.
  always_comb begin
    nxt_sel   = cur_sel_q;
    nxt_found = 1'b0;
    probe_idx = '0;
    for (int off = 1; off <= NCH; off++) begin
      probe_idx = SELW'((int'(cur_sel_q) + off) % NCH);
      if (!nxt_found && bus.chan_en[probe_idx]) begin
        nxt_found = 1'b1;
        nxt_sel   = probe_idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    cur_sel_d   = cur_sel_q;
    dwell_d     = dwell_q;
    sel_err_d   = 1'b0;
    scan_wrap_d = 1'b0;

    if (!bus.hold) begin
      case (state_q)
        // out/out_valid are still zero from reset and stay so this cycle.
        StIdle: state_d = bus.mode ? StScan : StMan;

        StMan: begin
          out_d       = ch_data[cur_sel_q];
          out_valid_d = 1'b1;
          if (bus.mode) begin
            // mode wins over a coincident sel_load.
            state_d = StScan;
            dwell_d = '0;
          end else if (bus.sel_load) begin
            if (sel_legal[bus.sel_in]) begin
              cur_sel_d = bus.sel_in;
            end else begin
              sel_err_d = 1'b1;
            end
          end
        end

        StScan: begin
          if (bus.chan_en == '0) begin
            // Nothing to show: keep out and cur_sel, mark invalid.
            out_valid_d = 1'b0;
            dwell_d     = '0;
          end else begin
            out_d       = ch_data[cur_sel_q];
            out_valid_d = cur_en;
            // A disabled current channel is skipped without waiting for dwell.
            if (bus.mode && (!cur_en || dwell_q == DwellLast)) begin
              cur_sel_d   = nxt_sel;
              dwell_d     = '0;
              scan_wrap_d = (nxt_sel < cur_sel_q);
            end else if (bus.mode) begin
              dwell_d = dwell_q + CNTW'(1);
            end
          end
          if (!bus.mode) begin
            state_d = StMan;
            dwell_d = '0;
          end
        end

        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      cur_sel_q   <= '0;
      dwell_q     <= '0;
      sel_err_q   <= 1'b0;
      scan_wrap_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      cur_sel_q   <= cur_sel_d;
      dwell_q     <= dwell_d;
      sel_err_q   <= sel_err_d;
      scan_wrap_q <= scan_wrap_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.cur_sel   = cur_sel_q;
  assign bus.sel_err   = sel_err_q;
  assign bus.scan_wrap = scan_wrap_q;

endmodule

// File: tb/tb_mux_scan_sel.sv
// Bench for mux_scan_sel: two instances (4 channels / dwell 4 and 3 channels /
// dwell 2) share one stimulus stream. A reference model predicts each
// instance's outputs after every clock edge; a monitor compares them.
module tb_mux_scan_sel;

  localparam int ST_IDLE = 0;
  localparam int ST_MAN  = 1;
  localparam int ST_SCAN = 2;

  typedef struct {
    int st;
    int out;
    bit valid;
    int sel;
    int dwell;
    bit err;
    bit wrap;
  } mstate_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mux_scan_sel_if #(.WIDTH(8), .NCH(4), .SELW(2)) if_a ();
  mux_scan_sel_if #(.WIDTH(8), .NCH(3), .SELW(2)) if_b ();

  mux_scan_sel #(.WIDTH(8), .NCH(4), .SELW(2), .DWELL(4)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a)
  );

  mux_scan_sel #(.WIDTH(8), .NCH(3), .SELW(2), .DWELL(2)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b)
  );

  // Stimulus variables, applied at each falling edge.
  logic       rst_v      = 1'b1;
  logic       hold_v     = 1'b0;
  logic       mode_v     = 1'b0;
  logic       sel_load_v = 1'b0;
  logic [1:0] sel_in_v   = '0;
  logic [3:0] en_v       = 4'hF;
  logic [7:0] din_v [4];

  mstate_t m_a, m_b;
  mstate_t q_a[$];
  mstate_t q_b[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model of one edge: channel order comes from a list of enabled
  // indices; the next channel is the smallest enabled index above the current
  // one, else the smallest enabled index overall.
  function automatic mstate_t model_step(mstate_t m, int nch, int dw, logic r, logic h,
                                         logic md, logic ld, int si, logic [3:0] en,
                                         logic [7:0] d [4]);
    int ens[$];
    int nxt;
    if (r) begin
      m = '{default: 0};
      return m;
    end
    m.err  = 0;
    m.wrap = 0;
    if (h) return m;
    case (m.st)
      ST_IDLE: m.st = md ? ST_SCAN : ST_MAN;
      ST_MAN: begin
        m.out   = int'(d[m.sel]);
        m.valid = 1;
        if (md) begin
          m.st    = ST_SCAN;
          m.dwell = 0;
        end else if (ld) begin
          if (si < nch) m.sel = si;
          else m.err = 1;
        end
      end
      default: begin
        for (int k = 0; k < nch; k++) if (en[k]) ens.push_back(k);
        if (ens.size() == 0) begin
          m.valid = 0;
          m.dwell = 0;
        end else begin
          m.out   = int'(d[m.sel]);
          m.valid = en[m.sel];
          if (md && (!en[m.sel] || m.dwell == dw - 1)) begin
            nxt = ens[0];
            for (int i = ens.size() - 1; i >= 0; i--) if (ens[i] > m.sel) nxt = ens[i];
            m.wrap  = (nxt < m.sel);
            m.sel   = nxt;
            m.dwell = 0;
          end else if (md) begin
            m.dwell++;
          end
        end
        if (!md) begin
          m.st    = ST_MAN;
          m.dwell = 0;
        end
      end
    endcase
    return m;
  endfunction

  task automatic check(string name, logic [31:0] act, int exp);
    n_checks++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus and queue the predicted post-edge outputs.
  task automatic tick();
    @(negedge clk);
    rst          = rst_v;
    if_a.din     = {din_v[3], din_v[2], din_v[1], din_v[0]};
    if_b.din     = {din_v[2], din_v[1], din_v[0]};
    if_a.mode    = mode_v;      if_b.mode     = mode_v;
    if_a.sel_in  = sel_in_v;    if_b.sel_in   = sel_in_v;
    if_a.sel_load = sel_load_v; if_b.sel_load = sel_load_v;
    if_a.chan_en = en_v;        if_b.chan_en  = en_v[2:0];
    if_a.hold    = hold_v;      if_b.hold     = hold_v;
    m_a = model_step(m_a, 4, 4, rst_v, hold_v, mode_v, sel_load_v, int'(sel_in_v), en_v, din_v);
    m_b = model_step(m_b, 3, 2, rst_v, hold_v, mode_v, sel_load_v, int'(sel_in_v),
                     {1'b0, en_v[2:0]}, din_v);
    q_a.push_back(m_a);
    q_b.push_back(m_b);
    sel_load_v = 1'b0;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Monitor: outputs are registered, so one prediction per clock edge.
  initial begin
    mstate_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        check("a.out",       if_a.out,       e.out);
        check("a.out_valid", if_a.out_valid, int'(e.valid));
        check("a.cur_sel",   if_a.cur_sel,   e.sel);
        check("a.sel_err",   if_a.sel_err,   int'(e.err));
        check("a.scan_wrap", if_a.scan_wrap, int'(e.wrap));
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        check("b.out",       if_b.out,       e.out);
        check("b.out_valid", if_b.out_valid, int'(e.valid));
        check("b.cur_sel",   if_b.cur_sel,   e.sel);
        check("b.sel_err",   if_b.sel_err,   int'(e.err));
        check("b.scan_wrap", if_b.scan_wrap, int'(e.wrap));
      end
    end
  end

  initial begin
    m_a = '{default: 0};
    m_b = '{default: 0};
    din_v = '{8'hA5, 8'h00, 8'h00, 8'h00};

    // Reset two cycles, then IDLE cycle, then manual on channel 0.
    rst_v = 1'b1;
    ticks(2);
    rst_v = 1'b0;
    ticks(3);

    // Manual loads: sel 2, then sel 3 (illegal on the 3-channel instance).
    din_v = '{8'h11, 8'h22, 8'h33, 8'h44};
    sel_in_v = 2'd2; sel_load_v = 1'b1;
    ticks(4);
    sel_in_v = 2'd3; sel_load_v = 1'b1;
    ticks(4);

    // Scan from channel 0 with mask 1011.
    sel_in_v = 2'd0; sel_load_v = 1'b1;
    ticks(2);
    en_v = 4'b1011;
    mode_v = 1'b1;
    ticks(30);

    // Empty mask, restore, then hold mid-dwell.
    en_v = 4'b0000;
    ticks(4);
    en_v = 4'b1011;
    ticks(6);
    hold_v = 1'b1;
    ticks(5);
    hold_v = 1'b0;
    ticks(8);

    // Reach channel 3 on the 4-channel instance, then reset under hold.
    for (int i = 0; i < 40 && m_a.sel != 3; i++) tick();
    hold_v = 1'b1;
    ticks(2);
    rst_v = 1'b1;
    tick();
    rst_v = 1'b0;
    hold_v = 1'b0;
    ticks(3);

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      rst_v      = ($urandom_range(0, 99) == 0);
      hold_v     = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 19) == 0) mode_v = ~mode_v;
      sel_load_v = ($urandom_range(0, 3) == 0);
      sel_in_v   = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 24) == 0) en_v = 4'($urandom_range(0, 15));
      for (int k = 0; k < 4; k++) din_v[k] = 8'($urandom);
      tick();
    end

    repeat (3) @(posedge clk);
    #2;
    check("drain_a", q_a.size(), 0);
    check("drain_b", q_b.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_scan_sel.md
Name: mux_scan_sel

Overview:
- Parametrised, registered N-channel, W-bit multiplexer with a single registered output.
- Manual mode: the channel select is loaded through a strobe.
- Scan mode: an internal sequencer steps round-robin through the enabled channels, holding each one for a programmable dwell time.
- Sits between the channel sources and downstream display/capture logic, and replaces the single-bit 2:1 select path.

Parameters:
- WIDTH, 8, data width per channel.
- NCH, 4, number of input channels (2..16).
- SELW, 2, select width; must equal ceil(log2(NCH)).
- DWELL, 4, cycles spent on each channel in scan mode (>=1).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  NCH*WIDTH  flattened channel data; channel k occupies din[k*WIDTH +: WIDTH].
- mode  in  1  0 = manual, 1 = scan.
- sel_in  in  SELW  channel index, used in manual mode.
- sel_load  in  1  single-cycle strobe that loads sel_in into cur_sel.
- chan_en  in  NCH  scan-mode enable mask; bit k enables channel k.
- hold  in  1  freezes out, cur_sel, dwell counter and state.
- out  out  WIDTH  registered selected data.
- out_valid  out  1  out holds data from a legal, enabled selection.
- cur_sel  out  SELW  currently selected channel.
- sel_err  out  1  one-cycle pulse when sel_in >= NCH is loaded.
- scan_wrap  out  1  one-cycle pulse when a scan advance wraps to a lower index.

Behaviour:
- Reset, sampled at the clk edge while rst=1:
  - out=0, out_valid=0, cur_sel=0, sel_err=0, scan_wrap=0.
  - dwell_cnt=0, state=IDLE.
  - rst has priority over every other input, including mid-scan and mid-hold.
- States:
  - IDLE: entered only from reset. Leaves on the first cycle with rst=0: to MAN if mode=0, to SCAN if mode=1. out and out_valid stay 0 for that cycle.
  - MAN: each cycle, out <= din[cur_sel] and out_valid <= 1.
  - SCAN: out <= din[cur_sel] and out_valid <= chan_en[cur_sel].
  - MAN<->SCAN transitions follow mode, sampled each cycle. On every transition dwell_cnt <= 0 and cur_sel is kept.
- Data latency:
  - Registered select to out: 1 cycle.
  - sel_load at edge k updates cur_sel at k+1; the new data appears on out at k+2.
- sel_load:
  - Honoured only in MAN with mode=0 sampled in the same cycle. Ignored in SCAN and IDLE, and when mode=1 in that cycle (mode wins).
  - If sel_in >= NCH: cur_sel is unchanged and sel_err pulses for one cycle.
- Scan sequencing:
  - dwell_cnt counts 0..DWELL-1.
  - When dwell_cnt=DWELL-1: cur_sel <= next enabled index strictly after cur_sel, modulo NCH; dwell_cnt <= 0.
  - If the new index < old index, scan_wrap pulses for one cycle.
  - If cur_sel is disabled on entry to SCAN, or when the mask changes, the advance happens on the next cycle without waiting for dwell.
  - If only one channel is enabled and cur_sel is that channel, cur_sel stays put and scan_wrap does not pulse.
- chan_en all zero in SCAN:
  - cur_sel holds, dwell_cnt holds at 0, out holds its last value, out_valid <= 0, no scan_wrap.
- hold=1:
  - out, out_valid, cur_sel, dwell_cnt and state all frozen.
  - sel_load is ignored; sel_err and scan_wrap stay 0.
  - Releasing hold resumes exactly where it stopped.
- No combinational path from any input to any output.

Test Plan:
- Reset/IDLE: assert rst 2 cycles with din ch0=8'hA5, mode=0, then release. Required: out=0 and out_valid=0 through reset and the IDLE cycle; next cycle out=8'hA5, out_valid=1, cur_sel=0.
- Manual load latency: MAN, din = {8'h44, 8'h33, 8'h22, 8'h11} (ch3..ch0), pulse sel_load with sel_in=2 at cycle k. Required: cur_sel=2 at k+1; out=8'h33 at k+2. A later pulse with sel_in=3 gives out=8'h44 two cycles after it.
- Illegal select (NCH=3, SELW=2): sel_load with sel_in=3. Required: sel_err high exactly 1 cycle; cur_sel and out unchanged.
- Scan with mask: mode=1, DWELL=4, chan_en=4'b1011, starting from cur_sel=0. Required: cur_sel sequence 0,1,3,0 with 4 cycles each; channel 2 never selected; scan_wrap pulses once per 3->0 advance.
- Empty mask and hold: in SCAN set chan_en=0. Required: out_valid=0 next cycle, cur_sel and out frozen. Restore the mask, then assert hold for 5 cycles mid-dwell. Required: no change to out or cur_sel during hold; dwell resumes on release.
- Reset mid-scan with hold=1 and cur_sel=3: assert rst 1 cycle. Required: all outputs return to reset values, state=IDLE.
